// File: rtl/pkt_traffic_gen_pkg.sv
// Shared types and constants for the packet traffic generator: FSM states,
// priority-mode encodings, default widths and the control-word layout.
package pkt_traffic_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_GAP     = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PRIO_LO     = 2'd0,
    PRIO_HI     = 2'd1,
    PRIO_ALT    = 2'd2,
    PRIO_LO_ALT = 2'd3
  } prio_mode_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 12;
  localparam int DEF_CTRL_W = 24;
  localparam int DEF_CNT_W  = 16;
  localparam int GAP_W      = 8;

  // Length field occupies ctrl_out[CTRL_LEN_LSB +: LEN_W]; all other bits are zero.
  localparam int CTRL_LEN_LSB = 0;

  // Priority of the first packet of a run for a given mode.
  function automatic logic first_prio(input prio_mode_t mode);
    return (mode == PRIO_HI) || (mode == PRIO_ALT);
  endfunction

endpackage

// File: rtl/pkt_traffic_gen.sv
// Packet traffic generator: emits runs of fixed-length packets with optional
// inter-packet gaps, per-packet control words and selectable priority.
module pkt_traffic_gen
  import pkt_traffic_gen_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [CNT_W-1:0]  cfg_num_pkts,
  input  logic [7:0]        cfg_gap,
  input  logic [1:0]        cfg_prio_mode,
  input  logic              cfg_const_en,
  input  logic [DATA_W-1:0] cfg_const_val,
  input  logic              ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              ctrl_valid,
  output logic              hi_priority,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  output logic [CNT_W-1:0]  pkt_count
);

  // One down-counter serves as byte counter in PAYLOAD and gap timer in GAP.
  localparam int BC_W = (LEN_W > GAP_W) ? LEN_W : GAP_W;

  state_t            state_reg, state_next;
  logic [BC_W-1:0]   cnt_reg, cnt_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [CNT_W-1:0]  num_reg, num_next;
  logic [GAP_W-1:0]  gap_reg, gap_next;
  prio_mode_t        mode_reg, mode_next;
  logic              const_en_reg, const_en_next;
  logic [DATA_W-1:0] const_val_reg, const_val_next;
  logic [DATA_W-1:0] payload_reg, payload_next;
  logic              first_reg, first_next;
  logic              prio_reg, prio_next;
  logic              stop_reg, stop_next;
  logic              err_reg, err_next;
  logic [CNT_W-1:0]  pkt_count_reg, pkt_count_next;

  logic              running;
  logic              xfer;
  logic              last_beat;
  logic              run_end;
  logic [CNT_W-1:0]  pkt_count_inc;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      len_reg       <= '0;
      num_reg       <= '0;
      gap_reg       <= '0;
      mode_reg      <= PRIO_LO;
      const_en_reg  <= 1'b0;
      const_val_reg <= '0;
      payload_reg   <= '0;
      first_reg     <= 1'b0;
      prio_reg      <= 1'b0;
      stop_reg      <= 1'b0;
      err_reg       <= 1'b0;
      pkt_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      len_reg       <= len_next;
      num_reg       <= num_next;
      gap_reg       <= gap_next;
      mode_reg      <= mode_next;
      const_en_reg  <= const_en_next;
      const_val_reg <= const_val_next;
      payload_reg   <= payload_next;
      first_reg     <= first_next;
      prio_reg      <= prio_next;
      stop_reg      <= stop_next;
      err_reg       <= err_next;
      pkt_count_reg <= pkt_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    len_next       = len_reg;
    num_next       = num_reg;
    gap_next       = gap_reg;
    mode_next      = mode_reg;
    const_en_next  = const_en_reg;
    const_val_next = const_val_reg;
    payload_next   = payload_reg;
    first_next     = first_reg;
    prio_next      = prio_reg;
    err_next       = err_reg;
    pkt_count_next = pkt_count_reg;

    running       = (state_reg == ST_PAYLOAD) || (state_reg == ST_GAP);
    xfer          = (state_reg == ST_PAYLOAD) && ready;
    last_beat     = xfer && (cnt_reg == BC_W'(1));
    pkt_count_inc = pkt_count_reg + CNT_W'(1);
    stop_next     = stop_reg | (stop & running);
    // A stop on the final beat itself also ends the run at that boundary.
    run_end       = stop_reg || stop ||
                    ((num_reg != '0) && (pkt_count_inc == num_reg));

    unique case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (cfg_len == '0) begin
            err_next   = 1'b1;
            state_next = ST_DONE;
          end else begin
            len_next       = cfg_len;
            num_next       = cfg_num_pkts;
            gap_next       = cfg_gap;
            mode_next      = prio_mode_t'(cfg_prio_mode);
            const_en_next  = cfg_const_en;
            const_val_next = cfg_const_val;
            prio_next      = first_prio(prio_mode_t'(cfg_prio_mode));
            pkt_count_next = '0;
            stop_next      = 1'b0;
            cnt_next       = BC_W'(cfg_len);
            first_next     = 1'b1;
            state_next     = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (xfer) begin
          first_next = 1'b0;
          if (!const_en_reg) payload_next = payload_reg + DATA_W'(1);
          if (last_beat) begin
            pkt_count_next = (pkt_count_reg == '1) ? pkt_count_reg : pkt_count_inc;
            if (mode_reg == PRIO_ALT) prio_next = ~prio_reg;
            first_next = 1'b1;
            cnt_next   = BC_W'(len_reg);
            if (run_end) begin
              stop_next  = 1'b0;
              state_next = ST_DONE;
            end else if (gap_reg != '0) begin
              cnt_next   = BC_W'(gap_reg);
              state_next = ST_GAP;
            end
          end else begin
            cnt_next = cnt_reg - BC_W'(1);
          end
        end
      end

      ST_GAP: begin
        if (stop_reg || stop) begin
          stop_next  = 1'b0;
          state_next = ST_DONE;
        end else if (cnt_reg == BC_W'(1)) begin
          cnt_next   = BC_W'(len_reg);
          state_next = ST_PAYLOAD;
        end else begin
          cnt_next = cnt_reg - BC_W'(1);
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_out = '0;
    if ((state_reg == ST_PAYLOAD) && first_reg) begin
      ctrl_out[CTRL_LEN_LSB +: LEN_W] = len_reg;
    end
  end

  assign data_out    = const_en_reg ? const_val_reg : payload_reg;
  assign data_valid  = (state_reg == ST_PAYLOAD);
  assign ctrl_valid  = (state_reg == ST_PAYLOAD) && first_reg;
  assign hi_priority = prio_reg;
  assign busy        = (state_reg == ST_PAYLOAD) || (state_reg == ST_GAP);
  assign done        = (state_reg == ST_DONE);
  assign err_len     = err_reg;
  assign pkt_count   = pkt_count_reg;

endmodule

// File: tb/tb_pkt_traffic_gen.sv
// Directed bench for pkt_traffic_gen: table-driven cycle vectors for the
// gap/priority and backpressure runs, plus hand-written multi-cycle sequences.
module tb_pkt_traffic_gen;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [11:0] cfg_len;
  logic [15:0] cfg_num_pkts;
  logic [7:0]  cfg_gap;
  logic [1:0]  cfg_prio_mode;
  logic        cfg_const_en;
  logic [7:0]  cfg_const_val;
  logic        ready;
  logic [7:0]  data_out;
  logic        data_valid;
  logic [23:0] ctrl_out;
  logic        ctrl_valid;
  logic        hi_priority;
  logic        busy;
  logic        done;
  logic        err_len;
  logic [15:0] pkt_count;

  pkt_traffic_gen dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .cfg_len       (cfg_len),
    .cfg_num_pkts  (cfg_num_pkts),
    .cfg_gap       (cfg_gap),
    .cfg_prio_mode (cfg_prio_mode),
    .cfg_const_en  (cfg_const_en),
    .cfg_const_val (cfg_const_val),
    .ready         (ready),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .ctrl_out      (ctrl_out),
    .ctrl_valid    (ctrl_valid),
    .hi_priority   (hi_priority),
    .busy          (busy),
    .done          (done),
    .err_len       (err_len),
    .pkt_count     (pkt_count)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic       rdy;
    logic       v;
    logic [7:0] d;
    logic       cv;
    logic       hi;
    logic       dn;
    logic       chk_dh;  // data/priority meaningful only on beats
  } vec_t;

  vec_t vec [0:31];
  int   nrows;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_row(input int i, input logic rdy, input logic v, input logic [7:0] d,
                         input logic cv, input logic hi, input logic dn, input logic chk);
    vec[i].rdy = rdy; vec[i].v = v; vec[i].d = d; vec[i].cv = cv;
    vec[i].hi = hi; vec[i].dn = dn; vec[i].chk_dh = chk;
  endtask

  task automatic apply_rows(input string tag, input logic [11:0] len);
    for (int i = 0; i < nrows; i++) begin
      ready = vec[i].rdy;
      check({tag, "_valid"}, 64'(data_valid), 64'(vec[i].v));
      check({tag, "_ctrlv"}, 64'(ctrl_valid), 64'(vec[i].cv));
      check({tag, "_ctrl"}, 64'(ctrl_out), vec[i].cv ? 64'(len) : 64'(0));
      check({tag, "_done"}, 64'(done), 64'(vec[i].dn));
      if (vec[i].chk_dh) begin
        check({tag, "_data"}, 64'(data_out), 64'(vec[i].d));
        check({tag, "_hi"}, 64'(hi_priority), 64'(vec[i].hi));
      end
      @(negedge clk_sys);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
  endtask

  task automatic run_start(input logic [11:0] len, input logic [15:0] num, input logic [7:0] gap,
                           input logic [1:0] prio, input logic cen, input logic [7:0] cval);
    cfg_len = len; cfg_num_pkts = num; cfg_gap = gap; cfg_prio_mode = prio;
    cfg_const_en = cen; cfg_const_val = cval;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    $display("run: len=%0d num=%0d gap=%0d prio=%0d const=%0d", len, num, gap, prio, cen);
  endtask

  logic [7:0] pay;
  logic [63:0] exp_beat;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; ready = 1'b1;
    cfg_len = '0; cfg_num_pkts = '0; cfg_gap = '0; cfg_prio_mode = '0;
    cfg_const_en = 1'b0; cfg_const_val = '0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    // Outputs after reset, checked while reset still asserted
    check("rst_outputs", {data_out, data_valid, ctrl_out, ctrl_valid, hi_priority, busy, done, err_len, pkt_count}, 64'(0));
    reset = 1'b0;

    // Gap and alternate priority: 1111 00 1111 00 1111
    run_start(12'd4, 16'd3, 8'd2, 2'd2, 1'b0, 8'h00);
    nrows = 17;
    set_row(0, 1, 1, 8'd0, 1, 1, 0, 1);  set_row(1, 1, 1, 8'd1, 0, 1, 0, 1);
    set_row(2, 1, 1, 8'd2, 0, 1, 0, 1);  set_row(3, 1, 1, 8'd3, 0, 1, 0, 1);
    set_row(4, 1, 0, 8'd0, 0, 0, 0, 0);  set_row(5, 1, 0, 8'd0, 0, 0, 0, 0);
    set_row(6, 1, 1, 8'd4, 1, 0, 0, 1);  set_row(7, 1, 1, 8'd5, 0, 0, 0, 1);
    set_row(8, 1, 1, 8'd6, 0, 0, 0, 1);  set_row(9, 1, 1, 8'd7, 0, 0, 0, 1);
    set_row(10, 1, 0, 8'd0, 0, 0, 0, 0); set_row(11, 1, 0, 8'd0, 0, 0, 0, 0);
    set_row(12, 1, 1, 8'd8, 1, 1, 0, 1); set_row(13, 1, 1, 8'd9, 0, 1, 0, 1);
    set_row(14, 1, 1, 8'd10, 0, 1, 0, 1); set_row(15, 1, 1, 8'd11, 0, 1, 0, 1);
    set_row(16, 1, 0, 8'd0, 0, 0, 1, 0);
    apply_rows("gap", 12'd4);
    check("gap_pkt_count", 64'(pkt_count), 64'd3);
    check("gap_busy", 64'(busy), 64'd0);

    // Backpressure: ready toggles, starting low; each byte held across the stall
    do_reset();
    run_start(12'd8, 16'd1, 8'd0, 2'd0, 1'b0, 8'h00);
    nrows = 17;
    for (int i = 0; i < 16; i++) set_row(i, 1'(i % 2), 1, 8'(i / 2), (i < 2), 0, 0, 1);
    set_row(16, 1, 0, 8'd0, 0, 0, 1, 0);
    apply_rows("bp", 12'd8);
    check("bp_pkt_count", 64'(pkt_count), 64'd1);

    // Basic run: 64 packets of 512 bytes, contiguous
    do_reset();
    ready = 1'b1;
    run_start(12'd512, 16'd64, 8'd0, 2'd1, 1'b0, 8'h00);
    for (int i = 0; i < 32768; i++) begin
      exp_beat = {29'd0, 1'b1, 8'(i), 1'b1, 24'(((i % 512) == 0) ? 512 : 0), (i % 512) == 0};
      check("basic_beat", {29'd0, data_valid, data_out, hi_priority, ctrl_out, ctrl_valid}, exp_beat);
      @(negedge clk_sys);
    end
    check("basic_done", {data_valid, done, busy}, 64'b010);
    check("basic_pkt_count", 64'(pkt_count), 64'd64);

    // Stop during beat 3 of a continuous run: packet completes, then DONE
    do_reset();
    run_start(12'd16, 16'd0, 8'd0, 2'd0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      stop = (i == 2);
      check("stop_beat", {data_valid, data_out}, {1'b1, 8'(i)});
      @(negedge clk_sys);
    end
    stop = 1'b0;
    check("stop_done", {data_valid, done, busy}, 64'b010);
    check("stop_pkt_count", 64'(pkt_count), 64'd1);
    pay = 8'd16;

    // Stop during GAP: DONE on the next cycle
    run_start(12'd2, 16'd0, 8'd5, 2'd0, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      check("sgap_beat", {data_valid, data_out}, {1'b1, pay});
      pay++;
      @(negedge clk_sys);
    end
    check("sgap_in_gap", {data_valid, busy, done}, 64'b010);
    stop = 1'b1;
    @(negedge clk_sys);
    stop = 1'b0;
    check("sgap_done", {data_valid, busy, done}, 64'b001);
    check("sgap_pkt_count", 64'(pkt_count), 64'd1);

    // Stop on the same cycle as the last beat: no gap, run ends
    run_start(12'd4, 16'd0, 8'd3, 2'd0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      stop = (i == 3);
      check("slast_beat", {data_valid, data_out}, {1'b1, pay});
      pay++;
      @(negedge clk_sys);
    end
    stop = 1'b0;
    check("slast_done", {data_valid, busy, done}, 64'b001);
    check("slast_pkt_count", 64'(pkt_count), 64'd1);

    // Zero length: error flag, DONE, no beats
    run_start(12'd0, 16'd1, 8'd0, 2'd0, 1'b0, 8'h00);
    check("err_flags", {err_len, done, data_valid, busy}, 64'b1100);
    @(negedge clk_sys);
    check("err_no_beat", {err_len, done, data_valid}, 64'b110);

    // Start while busy is ignored: 2 packets of 4, ctrl stays at len 4
    run_start(12'd4, 16'd2, 8'd0, 2'd0, 1'b0, 8'h00);
    check("busy_done_clr", {done, busy, err_len}, 64'b011);
    for (int i = 0; i < 8; i++) begin
      start = (i == 1);
      cfg_len = (i == 1) ? 12'd9 : 12'd4;
      cfg_num_pkts = (i == 1) ? 16'd1 : 16'd2;
      check("busy_beat", {data_valid, data_out, ctrl_valid, ctrl_out},
            {1'b1, pay, (i % 4) == 0, 24'(((i % 4) == 0) ? 4 : 0)});
      pay++;
      @(negedge clk_sys);
    end
    start = 1'b0;
    check("busy_end", {done, busy, data_valid}, 64'b100);
    check("busy_pkt_count", 64'(pkt_count), 64'd2);

    // Reset mid-packet: everything zero next cycle, fresh run from 0x00
    run_start(12'd8, 16'd1, 8'd0, 2'd1, 1'b0, 8'h00);
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    check("mid_rst_outputs", {data_out, data_valid, ctrl_out, ctrl_valid, hi_priority, busy, done, err_len, pkt_count}, 64'(0));
    reset = 1'b0;
    run_start(12'd2, 16'd1, 8'd0, 2'd1, 1'b0, 8'h00);
    check("mid_rst_fresh", {data_valid, data_out, ctrl_valid, hi_priority}, {1'b1, 8'h00, 1'b1, 1'b1});

    // Constant payload with mode 3 (low priority)
    do_reset();
    run_start(12'd3, 16'd1, 8'd0, 2'd3, 1'b1, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      check("const_beat", {data_valid, data_out, hi_priority}, {1'b1, 8'hA5, 1'b0});
      @(negedge clk_sys);
    end
    check("const_done", {done, data_valid}, 64'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_traffic_gen.md
PKT_TRAFFIC_GEN -- requirements
Module: pkt_traffic_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8: payload byte width.
REQ-002 SHALL have parameter LEN_W, default 12: packet length field width.
REQ-003 SHALL have parameter CTRL_W, default 24: control word width, with length in bits [LEN_W-1:0] and zeros above.
REQ-004 SHALL have parameter CNT_W, default 16: packet counter width.
REQ-005 SHALL have ports as follows; clock is clk_sys, reset is reset, synchronous, active-high.
- clk_sys  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  pulse; begins a run when IDLE or DONE
- stop  in  1  pulse; finish current packet, then go to DONE
- cfg_len  in  LEN_W  bytes per packet
- cfg_num_pkts  in  CNT_W  packets per run; 0 = continuous
- cfg_gap  in  8  idle cycles between packets
- cfg_prio_mode  in  2  0=lo, 1=hi, 2=alternate (first packet hi), 3=lo
- cfg_const_en  in  1  1 = constant payload cfg_const_val; 0 = incrementing payload
- cfg_const_val  in  DATA_W  constant payload value
- ready  in  1  downstream accept; a beat transfers when data_valid&&ready
- data_out  out  DATA_W  payload byte
- data_valid  out  1  payload beat valid
- ctrl_out  out  CTRL_W  control word
- ctrl_valid  out  1  high on the first beat of each packet only
- hi_priority  out  1  priority of current packet, constant for the whole packet
- busy  out  1  state is not IDLE and not DONE
- done  out  1  level; run complete
- err_len  out  1  sticky; start was received with cfg_len==0
- pkt_count  out  CNT_W  packets fully transferred in this run

Function
REQ-006 SHALL implement states IDLE, PAYLOAD, GAP and DONE.
REQ-007 start in IDLE or DONE with cfg_len!=0 SHALL, on the next cycle:
- latch all cfg_* inputs;
- clear pkt_count and done;
- enter PAYLOAD.
REQ-008 start with cfg_len==0 SHALL set err_len and enter DONE, with no beats transferred.
REQ-009 start while busy SHALL be ignored.
REQ-010 In PAYLOAD, data_valid SHALL be 1; the byte counter SHALL advance only on a transfer.
REQ-011 While ready=0, data_out, ctrl_out, ctrl_valid and hi_priority SHALL hold stable.
REQ-012 On the first beat of a packet, ctrl_valid SHALL be 1 and ctrl_out SHALL be {zeros, latched len}.
REQ-013 On all other beats, ctrl_out SHALL be 0 and ctrl_valid SHALL be 0.
REQ-014 Incrementing payload SHALL:
- start at 0 after reset;
- advance by 1 per transfer, modulo 2^DATA_W;
- continue across packets and across runs.
REQ-015 The transfer of beat cfg_len SHALL:
- increment pkt_count;
- go to GAP if latched gap>0, otherwise straight to PAYLOAD of the next packet with no bubble.
REQ-016 GAP SHALL hold data_valid=0 for exactly latched gap cycles, then return to PAYLOAD.
REQ-017 A run SHALL go to DONE on the last-beat transfer when pkt_count reaches a nonzero latched num_pkts.
REQ-018 stop SHALL be latched while busy; the run SHALL go to DONE at the next packet boundary.
REQ-019 stop during GAP SHALL go to DONE on the next cycle.
REQ-020 stop arriving on the same cycle as the last-beat transfer SHALL end the run there.
REQ-021 In alternate mode, priority SHALL toggle per packet; in other modes it SHALL be fixed.
REQ-022 pkt_count SHALL saturate at all ones in continuous mode.
REQ-023 In DONE, done SHALL be 1 and data_valid SHALL be 0; done SHALL clear only on an accepted start or on reset.

Reset
REQ-024 Reset SHALL put the block in IDLE and clear all outputs, the payload counter and the stop latch.
REQ-025 All outputs SHALL be 0 during and after reset, including err_len.
REQ-026 Reset during PAYLOAD SHALL drop data_valid on the following edge; no partial-packet completion is required.

Structure
REQ-027 A shared package SHALL hold:
- the state enumeration;
- prio_mode encodings;
- default widths;
- the ctrl length-field position.
REQ-028 The byte/gap counter SHALL be a single down-counter reused between PAYLOAD and GAP; no sub-module is required.
REQ-029 All logic SHALL be in the clk_sys domain; the phy domain is out of scope.

Verification
REQ-030 Scenario, basic run:
- stimulus: len=512, num=64, gap=0, prio=1, ready=1;
- response: 32768 contiguous beats with data 0x00..0xFF repeating, and ctrl_valid every 512th beat with ctrl_out=0x000200;
- also: hi_priority=1 throughout and done after the last beat.
REQ-031 Scenario, gap and alternate priority:
- stimulus: len=4, num=3, gap=2, prio=2;
- response: valid pattern 1111 00 1111 00 1111, with hi_priority 1,0,1 and pkt_count=3.
REQ-032 Scenario, backpressure: len=8 with ready toggling every cycle -> 8 transfers, data 0..7 with no skips or duplicates, outputs stable while ready=0.
REQ-033 Scenario, stop: stop during beat 3 of a len=16 continuous run -> the packet completes to beat 16, then DONE with pkt_count=1.
REQ-034 Scenario, errors: start with len=0 -> err_len=1 and done=1 with no valid beats; start while busy -> no effect.
REQ-035 Scenario, reset mid-packet: reset mid-packet -> all outputs 0 next cycle; a fresh run then starts with payload 0x00.
